sistema_counter_ctrl: RTL
=========================

SISTEMA_COUNTER_CTRL -- requirements
Module: sistema_counter_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 13, counter width in bits.
REQ-002 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port chipselect  input  1  Avalon-MM slave select.
REQ-005 SHALL have port address  input  2  register index.
REQ-006 SHALL have port write_n  input  1  active-low write strobe, qualified by chipselect.
REQ-007 SHALL have port writedata  input  32  write data.
REQ-008 SHALL have port readdata  output  32  registered read data.
REQ-009 SHALL have port event_in  input  1  asynchronous event pulse to be counted.
REQ-010 SHALL have port count_out  output  CNT_W  live count, feeds the data_counter PIO in_port.
REQ-011 SHALL have port irq  output  1  level interrupt request.

Function
REQ-012 Register map SHALL be: 0 COUNT (RO; any write clears count), 1 CONTROL (bit0 EN, bit1 ONESHOT, bit2 CLR self-clearing and reads 0, bit3 IE), 2 COMPARE (RW, CNT_W LSBs), 3 STATUS (bit0 MATCH W1C, bit1 OVF W1C, bit2 RUNNING RO).
REQ-013 readdata SHALL update every cycle from the current address, with 1-cycle latency; unused bits SHALL read 0.
REQ-014 event_in SHALL pass a 2-flop synchronizer then rising-edge detect; a counted edge increments count on the 3rd clk edge after event_in rises. Minimum event_in high and low widths: 2 clk cycles each.
REQ-015 FSM states SHALL be IDLE, RUN, DONE; the count SHALL increment only in RUN.
REQ-016 IDLE->RUN when CONTROL written with EN=1; RUN->IDLE and DONE->IDLE when EN written 0.
REQ-017 RUN->DONE when an increment makes count equal COMPARE and ONESHOT=1; DONE holds count and ignores edges.
REQ-018 MATCH SHALL set on the cycle an increment makes count equal COMPARE, in either ONESHOT mode.
REQ-019 An increment from 2^CNT_W-1 SHALL wrap to 0 and set OVF; COMPARE=0 SHALL match on that wrap.
REQ-020 CLR or a COUNT write SHALL zero count next cycle, take DONE->RUN if EN=1, and take priority over a same-cycle increment.
REQ-021 A W1C write coincident with a new set event SHALL leave the flag set.
REQ-022 RUNNING SHALL read 1 exactly in state RUN.

Reset
REQ-023 On reset_n low: state IDLE; count, COMPARE, CONTROL, STATUS, readdata, synchronizer flops and irq SHALL all be 0; release is synchronous to clk.

Configuration
REQ-024 With SISTEMA_COUNTER_CTRL_IRQ_EN defined: irq = IE & (MATCH | OVF), registered.
REQ-025 Without SISTEMA_COUNTER_CTRL_IRQ_EN: irq SHALL be tied 0, IE SHALL read 0 and ignore writes; the port list is unchanged.

Structure
REQ-026 Package sistema_counter_ctrl_pkg SHALL hold the register address constants, CONTROL/STATUS bit positions, the FSM state enum typedef and the CNT_W default.
REQ-027 The synchronizer plus edge detector SHALL be one sub-module, sistema_edge_sync; all other logic stays in sistema_counter_ctrl.

Verification
REQ-028 EN=1, 5 event pulses -> COUNT reads 5, RUNNING=1, STATUS=0x4.
REQ-029 COMPARE=3, ONESHOT=1, EN=1, 6 pulses -> count stops at 3, state DONE, MATCH=1, RUNNING=0.
REQ-030 Preload the count to 8191 via 8191 pulses, then 1 pulse -> count 0, OVF=1; with the macro and IE=1, irq=1; W1C 0x2 -> irq=0.
REQ-031 Write CLR in the same cycle as a counted edge -> count 0, no increment lost into the next value.
REQ-032 Assert reset_n mid-RUN with count=100 -> all outputs 0 immediately, state IDLE, later pulses are not counted.
REQ-033 Build without the macro, set IE=1 and force MATCH -> irq stays 0, CONTROL bit3 reads 0.

Source files
------------

// File: rtl/sistema_counter_ctrl_pkg.sv
// Shared definitions for the event counter controller: register map,
// CONTROL/STATUS bit positions, FSM state encoding and default width.
package sistema_counter_ctrl_pkg;

    localparam int unsigned CNT_W_DEF = 13;
    localparam int unsigned ADDR_W    = 2;
    localparam int unsigned DATA_W    = 32;

    // Register addresses
    localparam logic [ADDR_W-1:0] ADDR_COUNT   = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_CONTROL = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_COMPARE = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_STATUS  = 2'd3;

    // CONTROL bit positions
    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_ONESHOT = 1;
    localparam int unsigned CTRL_CLR     = 2;
    localparam int unsigned CTRL_IE      = 3;

    // STATUS bit positions
    localparam int unsigned STAT_MATCH   = 0;
    localparam int unsigned STAT_OVF     = 1;
    localparam int unsigned STAT_RUNNING = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/sistema_edge_sync.sv
// Two-flop synchronizer followed by a rising-edge detector.
// Ports:
//   clk       - system clock
//   reset_n   - asynchronous active-low reset
//   i_async   - asynchronous input level
//   o_rise_c  - combinational one-cycle pulse on a synchronized rising edge
module sistema_edge_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic i_async,
    output logic o_rise_c
);

    logic r_sync0;
    logic r_sync1;
    logic r_prev;

    // Synchronizer chain plus previous-value flop for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync0 <= i_async;
            r_sync1 <= r_sync0;
            r_prev  <= r_sync1;
        end
    end

    assign o_rise_c = r_sync1 & ~r_prev;

endmodule

// File: rtl/sistema_counter_ctrl.sv
// Avalon-MM controlled event counter with compare match, overflow and
// one-shot stop. Optional interrupt output enabled by the macro
// SISTEMA_COUNTER_CTRL_IRQ_EN (default build: irq tied 0, IE reads 0).
// Ports:
//   clk, reset_n          - clock, asynchronous active-low reset
//   chipselect, address,
//   write_n, writedata    - Avalon-MM slave write side
//   readdata              - registered read data (1-cycle latency)
//   event_in              - asynchronous event pulse to count
//   count_out             - live count value
//   irq                   - level interrupt request
module sistema_counter_ctrl
    import sistema_counter_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              chipselect,
    input  logic [ADDR_W-1:0] address,
    input  logic              write_n,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    input  logic              event_in,
    output logic [CNT_W-1:0]  count_out,
    output logic              irq
);

    state_e             r_state;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_compare;
    logic               r_en;
    logic               r_oneshot;
    logic               r_match;
    logic               r_ovf;
    logic [DATA_W-1:0]  r_readdata;

    logic               w_rise;
    logic               w_wr;
    logic               w_wr_count;
    logic               w_wr_control;
    logic               w_wr_compare;
    logic               w_wr_status;
    logic               w_cnt_clr;
    logic               w_inc;
    logic               w_wrap;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_hit;
    logic               w_match_set;
    logic               w_ovf_set;
    logic               w_ie;
    logic [DATA_W-1:0]  w_rd_data;
    logic               w_unused_wdata;

    sistema_edge_sync u_edge_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_async  (event_in),
        .o_rise_c (w_rise)
    );

    // Write decode
    assign w_wr         = chipselect & ~write_n;
    assign w_wr_count   = w_wr & (address == ADDR_COUNT);
    assign w_wr_control = w_wr & (address == ADDR_CONTROL);
    assign w_wr_compare = w_wr & (address == ADDR_COMPARE);
    assign w_wr_status  = w_wr & (address == ADDR_STATUS);

    // Clear beats a same-cycle increment
    assign w_cnt_clr   = w_wr_count | (w_wr_control & writedata[CTRL_CLR]);
    assign w_inc       = w_rise & (r_state == ST_RUN) & ~w_cnt_clr;
    assign w_cnt_inc   = r_count + CNT_W'(1);
    assign w_wrap      = &r_count;
    assign w_hit       = (w_cnt_inc == r_compare);
    assign w_match_set = w_inc & w_hit;
    assign w_ovf_set   = w_inc & w_wrap;

    assign w_unused_wdata = ^writedata;

`ifdef SISTEMA_COUNTER_CTRL_IRQ_EN
    logic r_ie;
    logic r_irq;

    // Interrupt enable and registered interrupt level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ie  <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            if (w_wr_control) begin
                r_ie <= writedata[CTRL_IE];
            end
            r_irq <= r_ie & (r_match | r_ovf);
        end
    end

    assign w_ie = r_ie;
    assign irq  = r_irq;
`else
    assign w_ie = 1'b0;
    assign irq  = 1'b0;
`endif

    // Read mux; unused bits stay 0
    always_comb begin
        w_rd_data = '0;
        case (address)
            ADDR_COUNT: begin
                w_rd_data[CNT_W-1:0] = r_count;
            end
            ADDR_CONTROL: begin
                w_rd_data[CTRL_EN]      = r_en;
                w_rd_data[CTRL_ONESHOT] = r_oneshot;
                w_rd_data[CTRL_IE]      = w_ie;
            end
            ADDR_COMPARE: begin
                w_rd_data[CNT_W-1:0] = r_compare;
            end
            default: begin
                w_rd_data[STAT_MATCH]   = r_match;
                w_rd_data[STAT_OVF]     = r_ovf;
                w_rd_data[STAT_RUNNING] = (r_state == ST_RUN);
            end
        endcase
    end

    // Registers, flags, counter and FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_compare  <= '0;
            r_en       <= 1'b0;
            r_oneshot  <= 1'b0;
            r_match    <= 1'b0;
            r_ovf      <= 1'b0;
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rd_data;

            if (w_wr_compare) begin
                r_compare <= writedata[CNT_W-1:0];
            end
            if (w_wr_control) begin
                r_en      <= writedata[CTRL_EN];
                r_oneshot <= writedata[CTRL_ONESHOT];
            end

            // A set event wins over a coincident W1C
            r_match <= w_match_set | (r_match & ~(w_wr_status & writedata[STAT_MATCH]));
            r_ovf   <= w_ovf_set   | (r_ovf   & ~(w_wr_status & writedata[STAT_OVF]));

            if (w_cnt_clr) begin
                r_count <= '0;
            end else if (w_inc) begin
                r_count <= w_cnt_inc;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_wr_control && writedata[CTRL_EN]) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_wr_control && !writedata[CTRL_EN]) begin
                        r_state <= ST_IDLE;
                    end else if (w_match_set && r_oneshot) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // DONE is only reachable with EN=1, so a clear restarts
                    if (w_wr_control && !writedata[CTRL_EN]) begin
                        r_state <= ST_IDLE;
                    end else if (w_cnt_clr) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign readdata  = r_readdata;
    assign count_out = r_count;

endmodule
